// File: rtl/mux_pkg.sv
// Shared definitions for the mux/arbiter family: select-mode encodings and a
// width helper for tools without $clog2.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: the first requester at or after ptr,
// scanning upward and wrapping modulo N_CH. ptr must be below N_CH.
module rr_pick #(
  parameter int N_CH = 8,
  localparam int SELW = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] gnt_idx,
  output logic            gnt_vld
);

  logic [SELW-1:0] idx_tab [N_CH];
  logic [N_CH-1:0] rot_req;

  // rot_req[k] is the request of the channel k places after ptr
  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_rot
      logic [SELW:0] sum;
      assign sum = {1'b0, ptr} + (SELW+1)'(gi);
      assign idx_tab[gi] = (sum >= (SELW+1)'(N_CH)) ? SELW'(sum - (SELW+1)'(N_CH))
                                                     : sum[SELW-1:0];
      assign rot_req[gi] = req[idx_tab[gi]];
    end
  endgenerate

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (rot_req[k]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx_tab[k];
      end
    end
  end

endmodule

// File: rtl/mux_n_rr.sv
// N-channel registered multiplexer with valid/ready on every port; grant is
// either an external select or a fair round-robin scan.
module mux_n_rr
  import mux_pkg::*;
#(
  parameter int N_CH = 8,
  parameter int DW   = 8,
  localparam int SELW = $clog2(N_CH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  input  logic [N_CH-1:0]    in_valid,
  input  logic [N_CH*DW-1:0] in_data,
  output logic [N_CH-1:0]    in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DW-1:0]      out_data,
  output logic [SELW-1:0]    out_ch
);

  localparam int NPAD = 1 << SELW;

  logic            out_valid_reg;
  logic [DW-1:0]   out_data_reg;
  logic [SELW-1:0] out_ch_reg;
  logic [SELW-1:0] ptr_reg;
  logic [SELW-1:0] ptr_next;

  logic            load_en;
  logic            xfer;
  logic [SELW-1:0] rr_idx;
  logic            rr_vld;
  logic [SELW-1:0] grant;
  logic            gnt_vld;

  // Pad to a full power of two so an out-of-range sel reads as "not valid"
  logic [NPAD-1:0] valid_pad;
  logic [DW-1:0]   data_pad [NPAD];

  generate
    for (genvar gi = 0; gi < NPAD; gi++) begin : g_pad
      if (gi < N_CH) begin : g_ch
        assign valid_pad[gi] = in_valid[gi];
        assign data_pad[gi]  = in_data[gi*DW +: DW];
      end else begin : g_none
        assign valid_pad[gi] = 1'b0;
        assign data_pad[gi]  = '0;
      end
    end
  endgenerate

  rr_pick #(.N_CH(N_CH)) u_pick (
    .req     (in_valid),
    .ptr     (ptr_reg),
    .gnt_idx (rr_idx),
    .gnt_vld (rr_vld)
  );

  assign load_en = !out_valid_reg || out_ready;

  always_comb begin
    grant   = sel;
    gnt_vld = valid_pad[sel];
    if (mode == MODE_RR) begin
      grant   = rr_idx;
      gnt_vld = rr_vld;
    end
  end

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_rdy
      assign in_ready[gi] = rst_n && load_en && gnt_vld && (grant == SELW'(gi));
    end
  endgenerate

  assign xfer     = |in_ready;
  assign ptr_next = (grant == SELW'(N_CH - 1)) ? '0 : grant + SELW'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_ch_reg    <= '0;
      ptr_reg       <= '0;
    end else if (load_en) begin
      if (xfer) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= data_pad[grant];
        out_ch_reg    <= grant;
        if (mode == MODE_RR) ptr_reg <= ptr_next;
      end else begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_ch    = out_ch_reg;

endmodule

// File: tb/tb_mux_n_rr.sv
// Scoreboard bench for mux_n_rr: an 8-channel and a 5-channel instance, each
// with a queue of expected {channel, data} words popped as the consumer drains.
module tb_mux_n_rr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // 8-channel instance
  logic        m8_rst_n, m8_mode, m8_out_ready, m8_out_valid;
  logic [2:0]  m8_sel, m8_out_ch;
  logic [7:0]  m8_in_valid, m8_in_ready, m8_out_data;
  logic [63:0] m8_in_data;

  // 5-channel instance
  logic        m5_rst_n, m5_mode, m5_out_ready, m5_out_valid;
  logic [2:0]  m5_sel, m5_out_ch;
  logic [4:0]  m5_in_valid, m5_in_ready;
  logic [7:0]  m5_out_data;
  logic [39:0] m5_in_data;

  mux_n_rr #(.N_CH(8), .DW(8)) u8 (
    .clk(clk), .rst_n(m8_rst_n), .mode(m8_mode), .sel(m8_sel),
    .in_valid(m8_in_valid), .in_data(m8_in_data), .in_ready(m8_in_ready),
    .out_valid(m8_out_valid), .out_ready(m8_out_ready),
    .out_data(m8_out_data), .out_ch(m8_out_ch)
  );

  mux_n_rr #(.N_CH(5), .DW(8)) u5 (
    .clk(clk), .rst_n(m5_rst_n), .mode(m5_mode), .sel(m5_sel),
    .in_valid(m5_in_valid), .in_data(m5_in_data), .in_ready(m5_in_ready),
    .out_valid(m5_out_valid), .out_ready(m5_out_ready),
    .out_data(m5_out_data), .out_ch(m5_out_ch)
  );

  logic [10:0] q8[$];
  logic [10:0] q5[$];
  logic [10:0] e8, e5;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One cycle: check in_ready at the falling edge, queue the word that
  // should be captured on the coming rising edge.
  task automatic step8(input logic exp_x, input int exp_ch);
    @(negedge clk);
    chk("m8_in_ready", 32'(m8_in_ready), exp_x ? (32'd1 << exp_ch) : 32'd0);
    if (exp_x) q8.push_back({3'(exp_ch), 8'(8'hA0 + exp_ch)});
    @(posedge clk);
    #1;
  endtask

  task automatic step5(input logic exp_x, input int exp_ch);
    @(negedge clk);
    chk("m5_in_ready", 32'(m5_in_ready), exp_x ? (32'd1 << exp_ch) : 32'd0);
    if (exp_x) q5.push_back({3'(exp_ch), 8'(8'hA0 + exp_ch)});
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (m8_out_valid === 1'b1 && m8_out_ready) begin
      if (q8.size() == 0) begin
        chk("m8_unexpected_word", 32'd1, 32'd0);
      end else begin
        e8 = q8.pop_front();
        $display("m8 word ch=%0d data=%0h", m8_out_ch, m8_out_data);
        chk("m8_out_ch", 32'(m8_out_ch), 32'(e8[10:8]));
        chk("m8_out_data", 32'(m8_out_data), 32'(e8[7:0]));
      end
    end
  end

  always @(negedge clk) begin
    if (m5_out_valid === 1'b1 && m5_out_ready) begin
      if (q5.size() == 0) begin
        chk("m5_unexpected_word", 32'd1, 32'd0);
      end else begin
        e5 = q5.pop_front();
        $display("m5 word ch=%0d data=%0h", m5_out_ch, m5_out_data);
        chk("m5_out_ch", 32'(m5_out_ch), 32'(e5[10:8]));
        chk("m5_out_data", 32'(m5_out_data), 32'(e5[7:0]));
      end
    end
  end

  initial begin
    m8_rst_n = 1'b0; m8_mode = 1'b1; m8_sel = 3'd0;
    m8_in_valid = 8'hFF; m8_out_ready = 1'b1;
    m5_rst_n = 1'b0; m5_mode = 1'b0; m5_sel = 3'd6;
    m5_in_valid = 5'h1F; m5_out_ready = 1'b1;
    for (int k = 0; k < 8; k++) m8_in_data[k*8 +: 8] = 8'hA0 + 8'(k);
    for (int k = 0; k < 5; k++) m5_in_data[k*8 +: 8] = 8'hA0 + 8'(k);

    // Reset held with every channel requesting
    for (int i = 0; i < 3; i++) begin
      step8(1'b0, 0);
      chk("m8_rst_out_valid", 32'(m8_out_valid), 32'd0);
      chk("m8_rst_out_data", 32'(m8_out_data), 32'd0);
      chk("m8_rst_out_ch", 32'(m8_out_ch), 32'd0);
    end
    m8_rst_n = 1'b1;

    // Round-robin fairness, no bubbles
    for (int i = 0; i < 16; i++) step8(1'b1, i % 8);

    // Fixed select sweep
    m8_mode = 1'b0;
    for (int i = 0; i < 8; i++) begin
      m8_sel = 3'(i);
      step8(1'b1, i);
    end

    // Selected channel not valid: no grant, slot empties
    m8_sel = 3'd5;
    m8_in_valid = 8'hDF;
    step8(1'b0, 0);
    chk("m8_nogrant_out_valid", 32'(m8_out_valid), 32'd0);

    // Sparse round-robin, then wrap from ptr 7 to channel 1
    m8_mode = 1'b1;
    m8_in_valid = 8'h44;
    step8(1'b1, 2);
    step8(1'b1, 6);
    step8(1'b1, 2);
    step8(1'b1, 6);
    m8_in_valid = 8'h02;
    step8(1'b1, 1);

    // Backpressure on a word from channel 3
    m8_mode = 1'b0;
    m8_in_valid = 8'hFF;
    m8_sel = 3'd3;
    step8(1'b1, 3);
    m8_out_ready = 1'b0;
    m8_sel = 3'd4;
    for (int i = 0; i < 4; i++) begin
      step8(1'b0, 0);
      chk("m8_bp_out_valid", 32'(m8_out_valid), 32'd1);
      chk("m8_bp_out_ch", 32'(m8_out_ch), 32'd3);
      chk("m8_bp_out_data", 32'(m8_out_data), 32'hA3);
    end
    m8_out_ready = 1'b1;
    step8(1'b1, 4);
    m8_in_valid = 8'h00;
    step8(1'b0, 0);
    step8(1'b0, 0);
    chk("m8_queue_empty", 32'(q8.size()), 32'd0);

    // 5-channel: reset, then out-of-range select never grants
    step5(1'b0, 0);
    step5(1'b0, 0);
    chk("m5_rst_out_valid", 32'(m5_out_valid), 32'd0);
    m5_rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step5(1'b0, 0);
      chk("m5_sel6_out_valid", 32'(m5_out_valid), 32'd0);
    end
    m5_sel = 3'd4;
    step5(1'b1, 4);

    // Round-robin over a non-power-of-two channel count
    m5_mode = 1'b1;
    for (int i = 0; i < 12; i++) step5(1'b1, i % 5);

    // Reset mid-stream: pointer restarts at channel 0
    m5_rst_n = 1'b0;
    step5(1'b0, 0);
    chk("m5_midrst_out_valid", 32'(m5_out_valid), 32'd0);
    m5_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step5(1'b1, i);
    m5_in_valid = 5'h00;
    step5(1'b0, 0);
    step5(1'b0, 0);
    chk("m5_queue_empty", 32'(q5.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
